ycbcr2rgb_dsp: RTL and testbench

Streaming fixed-point YCbCr-to-RGB reconstruction block. It is the inverse of the fixed-point luma extractor and is used on the display/output side of the pixel path. It accepts one {Y,Cb,Cr} pixel per beat over a valid/ready handshake and emits a 24-bit RGB pixel. The datapath is a 3-stage pipeline using BT.601 full-range Q8 coefficients, with rounding and saturation on every output channel.

---
 rtl/ycbcr2rgb_dsp.sv | 116 +++++++++++
 tb/tb_ycbcr2rgb_dsp.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/ycbcr2rgb_dsp.sv
// Streaming YCbCr (BT.601 full range) to RGB converter, Q8 coefficients,
// three-stage valid/ready pipeline with rounding and saturation per channel.
module ycbcr2rgb_dsp #(
    parameter int unsigned COEF_RV = 359,
    parameter int unsigned COEF_GU = 88,
    parameter int unsigned COEF_GV = 183,
    parameter int unsigned COEF_BU = 454
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [23:0] s_ycbcr,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [23:0] m_rgb
);

    localparam logic signed [18:0] K_RV = 19'(COEF_RV);
    localparam logic signed [18:0] K_GU = 19'(COEF_GU);
    localparam logic signed [18:0] K_GV = 19'(COEF_GV);
    localparam logic signed [18:0] K_BU = 19'(COEF_BU);

    logic               run;
    logic               v1, v2, v3;
    logic               adv1, adv2, adv3;
    logic               in_fire;

    logic [7:0]         s1_y;
    logic signed [8:0]  s1_u, s1_v;

    logic signed [18:0] s2_y, s2_rv, s2_gu, s2_gv, s2_bu;
    logic signed [18:0] sum_r, sum_g, sum_b;

    function automatic logic [7:0] clamp8(input logic signed [18:0] s);
        logic signed [10:0] q;
        q = s[18:8];
        if (q < 11'sd0)
            return 8'h00;
        else if (q > 11'sd255)
            return 8'hFF;
        else
            return q[7:0];
    endfunction

    // Stages advance whenever the stage ahead is empty or draining
    assign adv3    = !v3 || m_ready;
    assign adv2    = !v2 || adv3;
    assign adv1    = !v1 || adv2;
    assign s_ready = run && adv1;
    assign in_fire = s_valid && s_ready;
    assign m_valid = v3;

    always_comb begin
        sum_r = s2_y + s2_rv + 19'sd128;
        sum_g = s2_y - s2_gu - s2_gv + 19'sd128;
        sum_b = s2_y + s2_bu + 19'sd128;
    end

    // run holds off input acceptance until the first edge after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            run <= 1'b0;
        else
            run <= 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1   <= 1'b0;
            s1_y <= '0;
            s1_u <= '0;
            s1_v <= '0;
        end else if (adv1) begin
            v1 <= in_fire;
            if (in_fire) begin
                s1_y <= s_ycbcr[23:16];
                s1_u <= $signed({1'b0, s_ycbcr[15:8]} - 9'd128);
                s1_v <= $signed({1'b0, s_ycbcr[7:0]} - 9'd128);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2    <= 1'b0;
            s2_y  <= '0;
            s2_rv <= '0;
            s2_gu <= '0;
            s2_gv <= '0;
            s2_bu <= '0;
        end else if (adv2) begin
            v2 <= v1;
            if (v1) begin
                s2_y  <= $signed(19'({s1_y, 8'h00}));
                s2_rv <= K_RV * 19'(s1_v);
                s2_gu <= K_GU * 19'(s1_u);
                s2_gv <= K_GV * 19'(s1_v);
                s2_bu <= K_BU * 19'(s1_u);
            end
        end
    end

    // m_rgb only updates on a new pixel, so it keeps the last value after a drain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v3    <= 1'b0;
            m_rgb <= '0;
        end else if (adv3) begin
            v3 <= v2;
            if (v2)
                m_rgb <= {clamp8(sum_r), clamp8(sum_g), clamp8(sum_b)};
        end
    end

endmodule

// File: tb/tb_ycbcr2rgb_dsp.sv
// Self-checking bench for ycbcr2rgb_dsp: directed vectors, backpressure,
// mid-stream reset and randomized traffic against a real-arithmetic model.
module tb_ycbcr2rgb_dsp;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [23:0] s_ycbcr = '0;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [23:0] m_rgb;

    always #5 clk = ~clk;

    ycbcr2rgb_dsp #(
        .COEF_RV(359),
        .COEF_GU(88),
        .COEF_GV(183),
        .COEF_BU(454)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_ycbcr (s_ycbcr),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_rgb   (m_rgb)
    );

    typedef struct {
        logic [23:0] pix;
        logic [23:0] exp;
    } vec_t;

    int          total = 0;
    int          bad = 0;
    logic [23:0] exp_q[$];
    logic        hold_pending = 1'b0;
    logic [23:0] hold_val = '0;
    logic        smp_sr, smp_mv, smp_in, smp_out;
    logic [23:0] smp_rgb;

    function automatic int sat8(input real x);
        int r;
        r = int'($floor(x + 0.5));
        if (r < 0) r = 0;
        if (r > 255) r = 255;
        return r;
    endfunction

    // Full-range BT.601 with the Q8 gains expressed as exact fractions
    function automatic logic [23:0] ref_rgb(input logic [23:0] p);
        real y, u, v;
        int  r, g, b;
        y = real'(int'(p[23:16]));
        u = real'(int'(p[15:8])) - 128.0;
        v = real'(int'(p[7:0])) - 128.0;
        r = sat8(y + (359.0 / 256.0) * v);
        g = sat8(y - (88.0 / 256.0) * u - (183.0 / 256.0) * v);
        b = sat8(y + (454.0 / 256.0) * u);
        return {r[7:0], g[7:0], b[7:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock: sample away from the edge, score transfers, then step past posedge
    task automatic cycle();
        @(negedge clk);
        smp_sr  = s_ready;
        smp_mv  = m_valid;
        smp_rgb = m_rgb;
        smp_in  = s_valid && s_ready;
        smp_out = m_valid && m_ready;
        if (hold_pending) begin
            chk("hold_valid", 32'(m_valid), 32'd1);
            chk("hold_rgb", 32'(m_rgb), 32'(hold_val));
        end
        hold_pending = m_valid && !m_ready;
        hold_val     = m_rgb;
        if (smp_in) exp_q.push_back(ref_rgb(s_ycbcr));
        if (smp_out) begin
            if (exp_q.size() == 0)
                chk("unexpected_out", 32'(m_rgb), 32'hFFFF_FFFF);
            else
                chk("stream_data", 32'(m_rgb), 32'(exp_q.pop_front()));
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t        tbl[4];
        logic [23:0] bp[6];
        int          idx, outs, gaps;

        tbl[0] = '{pix: 24'h808080, exp: 24'h808080};
        tbl[1] = '{pix: 24'h4C55FF, exp: 24'hFE0000};
        tbl[2] = '{pix: 24'hFF80FF, exp: 24'hFFA4FF};
        tbl[3] = '{pix: 24'h000000, exp: 24'h008800};

        bp[0] = 24'h808080; bp[1] = 24'h4C55FF; bp[2] = 24'hFF80FF;
        bp[3] = 24'h000000; bp[4] = 24'h1234AB; bp[5] = 24'hC0FFEE;

        #3;
        chk("rst_mvalid", 32'(m_valid), 32'd0);
        chk("rst_mrgb", 32'(m_rgb), 32'd0);
        chk("rst_sready", 32'(s_ready), 32'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("sready_after_rst", 32'(s_ready), 32'd1);

        for (int i = 0; i < 4; i++) begin
            m_ready = 1'b1;
            s_valid = 1'b1;
            s_ycbcr = tbl[i].pix;
            cycle();
            chk("tbl_accept", 32'(smp_in), 32'd1);
            s_valid = 1'b0;
            cycle();
            chk("lat_edge1", 32'(smp_mv), 32'd0);
            cycle();
            chk("lat_edge2", 32'(smp_mv), 32'd0);
            cycle();
            chk("lat_edge3", 32'(smp_mv), 32'd1);
            chk("tbl_rgb", 32'(smp_rgb), 32'(tbl[i].exp));
        end

        m_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 8; c++) begin
            s_valid = 1'b1;
            s_ycbcr = bp[idx];
            cycle();
            if (smp_in) idx++;
        end
        chk("bp_accepts", 32'(idx), 32'd3);
        chk("bp_sready", 32'(smp_sr), 32'd0);
        chk("bp_mvalid", 32'(smp_mv), 32'd1);
        chk("bp_first_held", 32'(smp_rgb), 32'(ref_rgb(bp[0])));

        m_ready = 1'b1;
        outs = 0;
        gaps = 0;
        for (int c = 0; c < 20 && outs < 6; c++) begin
            s_valid = (idx < 6);
            s_ycbcr = (idx < 6) ? bp[idx] : 24'h0;
            cycle();
            if (smp_in) idx++;
            if (smp_out) outs++;
            else if (outs > 0) gaps++;
        end
        s_valid = 1'b0;
        chk("bp_out_count", 32'(outs), 32'd6);
        chk("bp_gaps", 32'(gaps), 32'd0);

        m_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            s_valid = 1'b1;
            s_ycbcr = bp[4 + c];
            cycle();
        end
        s_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_mvalid", 32'(m_valid), 32'd0);
        chk("midrst_mrgb", 32'(m_rgb), 32'd0);
        chk("midrst_sready", 32'(s_ready), 32'd0);
        exp_q.delete();
        hold_pending = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;

        m_ready = 1'b1;
        s_valid = 1'b1;
        s_ycbcr = 24'h808080;
        outs = 0;
        for (int c = 0; c < 10; c++) begin
            cycle();
            if (smp_in) s_valid = 1'b0;
            if (smp_out) begin
                outs++;
                if (outs == 1) chk("midrst_first_out", 32'(smp_rgb), 32'h808080);
            end
        end
        chk("midrst_out_count", 32'(outs), 32'd1);

        for (int c = 0; c < 600; c++) begin
            s_valid = ($urandom_range(0, 3) != 0);
            m_ready = ($urandom_range(0, 3) != 0);
            s_ycbcr = 24'($urandom);
            cycle();
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        for (int c = 0; c < 20 && exp_q.size() != 0; c++)
            cycle();
        chk("drain_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
